// File: rtl/ahb_mem_slave.sv
// AHB-style memory slave: 64-bit little-endian words, programmable wait states,
// and a two-cycle error response for out-of-range, oversize or misaligned transfers.
module ahb_mem_slave #(
    parameter int unsigned DEPTH_WORDS = 512,
    parameter logic [63:0] BASE_ADDR   = 64'h0,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        HSEL,
    input  logic        HTRANS,
    input  logic [63:0] HADDR,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [63:0] HWDATA,
    output logic [63:0] HRDATA,
    output logic        HREADY,
    output logic        HRESP
);
    localparam int unsigned IDX_W      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [63:0] SPAN_BYTES = 64'(DEPTH_WORDS) << 3;
    localparam logic [2:0]  WAIT_LOAD  = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    typedef enum logic [2:0] {IDLE, WAIT, DATA, ERR1, ERR2} state_t;

    state_t            state;
    logic [2:0]        wait_cnt;
    logic [63:0]       addr_q;
    logic              write_q;
    logic [2:0]        size_q;
    logic              ready_q;
    logic              resp_q;
    logic [63:0]       mem [DEPTH_WORDS];

    logic [63:0]       offset;
    logic              aligned;
    logic              legal;
    logic              accept;
    logic [IDX_W-1:0]  idx;
    logic [7:0]        size_mask;
    logic [7:0]        byte_en;

    always_comb begin
        offset = HADDR - BASE_ADDR;
        case (HSIZE)
            3'd1:    aligned = (HADDR[0] == 1'b0);
            3'd2:    aligned = (HADDR[1:0] == 2'b00);
            3'd3:    aligned = (HADDR[2:0] == 3'b000);
            default: aligned = 1'b1;
        endcase
        legal  = (offset < SPAN_BYTES) && (HSIZE <= 3'd3) && aligned;
        accept = HSEL && HTRANS && ready_q;
    end

    always_comb begin
        idx = IDX_W'((addr_q - BASE_ADDR) >> 3);
        case (size_q)
            3'd0:    size_mask = 8'h01;
            3'd1:    size_mask = 8'h03;
            3'd2:    size_mask = 8'h0F;
            default: size_mask = 8'hFF;
        endcase
        byte_en = size_mask << addr_q[2:0];
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state    <= IDLE;
            wait_cnt <= '0;
            addr_q   <= '0;
            write_q  <= 1'b0;
            size_q   <= '0;
            ready_q  <= 1'b1;
            resp_q   <= 1'b0;
        end else begin
            case (state)
                WAIT: begin
                    if (wait_cnt == 3'd0) begin
                        state   <= DATA;
                        ready_q <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end
                ERR1: begin
                    state   <= ERR2;
                    ready_q <= 1'b1;
                    resp_q  <= 1'b1;
                end
                default: begin
                    // IDLE, DATA and ERR2 all end with HREADY high, so the next address pipelines in here
                    if (accept) begin
                        addr_q  <= HADDR;
                        write_q <= HWRITE;
                        size_q  <= HSIZE;
                        if (!legal) begin
                            state   <= ERR1;
                            ready_q <= 1'b0;
                            resp_q  <= 1'b1;
                        end else if (WAIT_STATES > 0) begin
                            state    <= WAIT;
                            wait_cnt <= WAIT_LOAD;
                            ready_q  <= 1'b0;
                            resp_q   <= 1'b0;
                        end else begin
                            state   <= DATA;
                            ready_q <= 1'b1;
                            resp_q  <= 1'b0;
                        end
                    end else begin
                        state   <= IDLE;
                        ready_q <= 1'b1;
                        resp_q  <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Reset on the edge that would end DATA drops the pending write.
    always_ff @(posedge CLK) begin
        if (RST_N && (state == DATA) && write_q) begin
            for (int unsigned b = 0; b < 8; b++) begin
                if (byte_en[b]) begin
                    mem[idx][8*b +: 8] <= HWDATA[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        HRDATA = '0;
        if ((state == DATA) && !write_q) begin
            HRDATA = mem[idx];
        end
    end

    assign HREADY = ready_q;
    assign HRESP  = resp_q;

endmodule

// File: tb/tb_ahb_mem_slave.sv
// Bench for ahb_mem_slave: two instances (WAIT_STATES=1 and 0) driven by directed and
// random transfers, checked every cycle against a transaction-level memory model.
module tb_ahb_mem_slave;
    localparam int DEPTH = 512;
    localparam int MAXT  = 256;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]       rst_n, hsel, htrans, hwrite, hready, hresp;
    logic [1:0][63:0] haddr, hwdata, hrdata;
    logic [1:0][2:0]  hsize;

    ahb_mem_slave #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(64'h0), .WAIT_STATES(1)) u_ws1 (
        .CLK(clk), .RST_N(rst_n[0]), .HSEL(hsel[0]), .HTRANS(htrans[0]), .HADDR(haddr[0]),
        .HWRITE(hwrite[0]), .HSIZE(hsize[0]), .HWDATA(hwdata[0]), .HRDATA(hrdata[0]),
        .HREADY(hready[0]), .HRESP(hresp[0])
    );

    ahb_mem_slave #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(64'h0), .WAIT_STATES(0)) u_ws0 (
        .CLK(clk), .RST_N(rst_n[1]), .HSEL(hsel[1]), .HTRANS(htrans[1]), .HADDR(haddr[1]),
        .HWRITE(hwrite[1]), .HSIZE(hsize[1]), .HWDATA(hwdata[1]), .HRDATA(hrdata[1]),
        .HREADY(hready[1]), .HRESP(hresp[1])
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Transaction-level model: byte-addressed memory plus the one transfer currently in its data phase.
    bit [63:0]   mdl  [2][DEPTH];
    bit [7:0]    mval [2][DEPTH];
    bit          m_active [2];
    int          m_left   [2];
    logic [63:0] m_addr   [2];
    bit          m_wr     [2];
    logic [2:0]  m_size   [2];
    bit          m_legal  [2];

    function automatic int ws_of(input int d);
        return (d == 0) ? 1 : 0;
    endfunction

    function automatic bit legal_fn(input logic [63:0] a, input logic [2:0] s);
        if (s > 3'd3) return 1'b0;
        if (a >= 64'(DEPTH) * 8) return 1'b0;
        return (a % (64'd1 << s)) == 64'd0;
    endfunction

    always @(posedge clk) begin : model
        int w;
        int ln;
        for (int d = 0; d < 2; d++) begin
            if (!rst_n[d]) begin
                m_active[d] = 1'b0;
            end else if (m_active[d] && m_left[d] > 0) begin
                m_left[d]--;
            end else begin
                if (m_active[d] && m_legal[d] && m_wr[d]) begin
                    w = int'(m_addr[d] >> 3);
                    for (int b = 0; b < (1 << m_size[d]); b++) begin
                        ln = int'(m_addr[d][2:0]) + b;
                        mdl[d][w][8*ln +: 8] = hwdata[d][8*ln +: 8];
                        mval[d][w][ln] = 1'b1;
                    end
                end
                if (hsel[d] && htrans[d]) begin
                    m_active[d] = 1'b1;
                    m_addr[d]   = haddr[d];
                    m_wr[d]     = hwrite[d];
                    m_size[d]   = hsize[d];
                    m_legal[d]  = legal_fn(haddr[d], hsize[d]);
                    m_left[d]   = m_legal[d] ? ws_of(d) : 1;
                end else begin
                    m_active[d] = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin : compare
        int w;
        logic er, es;
        logic [63:0] ed, mask;
        if (chk_en) begin
            for (int d = 0; d < 2; d++) begin
                er = 1'b1; es = 1'b0; ed = '0; mask = '1;
                if (m_active[d]) begin
                    es = !m_legal[d];
                    if (m_left[d] > 0) begin
                        er = 1'b0;
                    end else if (m_legal[d] && !m_wr[d]) begin
                        w  = int'(m_addr[d] >> 3);
                        ed = mdl[d][w];
                        for (int b = 0; b < 8; b++) mask[8*b +: 8] = {8{mval[d][w][b]}};
                    end
                end
                checks++;
                if (hready[d] !== er) begin
                    errors++;
                    $display("FAIL hready dut%0d @%0t: got %0b required %0b", d, $time, hready[d], er);
                end
                checks++;
                if (hresp[d] !== es) begin
                    errors++;
                    $display("FAIL hresp dut%0d @%0t: got %0b required %0b", d, $time, hresp[d], es);
                end
                checks++;
                if ((hrdata[d] & mask) !== (ed & mask)) begin
                    errors++;
                    $display("FAIL hrdata dut%0d @%0t: got %h required %h (mask %h)", d, $time, hrdata[d], ed, mask);
                end
            end
        end
    end

    // Transfer list and per-transfer observations gathered by the driver.
    bit          s_wr    [MAXT];
    logic [63:0] s_addr  [MAXT];
    logic [2:0]  s_size  [MAXT];
    logic [63:0] s_wdata [MAXT];
    int          s_n;
    logic [63:0] r_rdata [MAXT];
    bit          r_resp  [MAXT];
    int          r_lows  [MAXT];
    bit          r_err1  [MAXT];

    task automatic chk(input string nm, input int d, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %h required %h", nm, d, got, exp);
        end
    endtask

    task automatic add(input bit wr, input logic [63:0] a, input logic [2:0] s, input logic [63:0] wd);
        s_wr[s_n] = wr; s_addr[s_n] = a; s_size[s_n] = s; s_wdata[s_n] = wd;
        s_n++;
    endtask

    task automatic drive_idle(input int d);
        int k;
        k = $urandom_range(0, 2);
        hsel[d]   = (k == 1);
        htrans[d] = (k == 2);
        haddr[d]  = {$urandom, $urandom};
        hwrite[d] = 1'($urandom_range(0, 1));
        hsize[d]  = 3'($urandom_range(0, 7));
    endtask

    task automatic run_seq(input int d, input bit gap);
        int cur, nxt, guard;
        bit presented, rdy;
        cur = -1; nxt = 0; guard = 0;
        for (int i = 0; i < s_n; i++) begin
            r_rdata[i] = '0; r_resp[i] = 1'b0; r_lows[i] = 0; r_err1[i] = 1'b0;
        end
        while ((cur >= 0 || nxt < s_n) && guard < 16 * (s_n + 1)) begin
            presented = (nxt < s_n) && !(gap && cur >= 0);
            if (presented) begin
                hsel[d] = 1'b1; htrans[d] = 1'b1; haddr[d] = s_addr[nxt];
                hwrite[d] = s_wr[nxt]; hsize[d] = s_size[nxt];
            end else begin
                drive_idle(d);
            end
            hwdata[d] = (cur >= 0 && s_wr[cur]) ? s_wdata[cur] : {$urandom, $urandom};
            @(negedge clk);
            rdy = hready[d];
            if (cur >= 0) begin
                if (!rdy) begin
                    r_lows[cur]++;
                    if (hresp[d]) r_err1[cur] = 1'b1;
                end else begin
                    r_rdata[cur] = hrdata[d];
                    r_resp[cur]  = hresp[d];
                end
            end
            @(posedge clk); #1;
            if (rdy) begin
                cur = presented ? nxt : -1;
                if (presented) nxt++;
            end
            guard++;
        end
        if (cur >= 0 || nxt < s_n) begin
            checks++; errors++;
            $display("FAIL run_seq_timeout dut%0d: got %0d of %0d accepted, required all", d, nxt, s_n);
        end
        drive_idle(d);
    endtask

    task automatic reset_during(input int d, input logic [63:0] a, input logic [63:0] wd, input int after);
        bit rdy;
        int tries;
        tries = 0;
        hsel[d] = 1'b1; htrans[d] = 1'b1; hwrite[d] = 1'b1; haddr[d] = a; hsize[d] = 3'd3; hwdata[d] = wd;
        do begin
            @(negedge clk); rdy = hready[d];
            @(posedge clk); #1;
            tries++;
        end while (!rdy && tries < 20);
        if (!rdy) begin
            checks++; errors++;
            $display("FAIL reset_accept_timeout dut%0d: got no acceptance, required one", d);
        end
        drive_idle(d);
        hwdata[d] = wd;
        repeat (after) begin @(posedge clk); #1; end
        rst_n[d] = 1'b0;
        hsel[d] = 1'b1; htrans[d] = 1'b1; hwrite[d] = 1'b1; haddr[d] = a;
        @(posedge clk); #1;
        rst_n[d] = 1'b1;
        drive_idle(d);
        @(negedge clk);
        chk("post_reset_hready", d, 64'(hready[d]), 64'd1);
        chk("post_reset_hresp", d, 64'(hresp[d]), 64'd0);
        chk("post_reset_hrdata", d, hrdata[d], 64'd0);
        @(posedge clk); #1;
    endtask

    task automatic add_random();
        int r;
        logic [63:0] w;
        logic [2:0] s;
        logic [63:0] b;
        r = $urandom_range(0, 19);
        if (r < 16)       w = 64'(r);
        else if (r < 18)  w = 64'd511;
        else if (r == 18) w = 64'd512;
        else              w = 64'h1FFF_FFFF_FFFF_FFFE;
        s = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
        b = 64'($urandom_range(0, 7));
        if ($urandom_range(0, 7) != 0 && s <= 3'd3) b = b & ~((64'd1 << s) - 64'd1);
        add(1'($urandom_range(0, 1)), (w << 3) | b, s, {$urandom, $urandom});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no end of test, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = '0; hsel = '0; htrans = '0; hwrite = '0; haddr = '0; hwdata = '0; hsize = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = '1;
        chk_en = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("reset_hready", d, 64'(hready[d]), 64'd1);
            chk("reset_hresp", d, 64'(hresp[d]), 64'd0);
            chk("reset_hrdata", d, hrdata[d], 64'd0);
        end
        @(posedge clk); #1;

        // One wait state: dword write then read, both pipelined.
        s_n = 0;
        add(1'b1, 64'h10, 3'd3, 64'h1122334455667788);
        add(1'b0, 64'h10, 3'd3, 64'h0);
        run_seq(0, 1'b0);
        chk("ws1_write_lows", 0, 64'(r_lows[0]), 64'd1);
        chk("ws1_read_lows", 0, 64'(r_lows[1]), 64'd1);
        chk("ws1_read_data", 0, r_rdata[1], 64'h1122334455667788);
        chk("ws1_read_resp", 0, 64'(r_resp[1]), 64'd0);

        s_n = 0;
        add(1'b1, 64'h13, 3'd0, 64'hCCCCCCCC_ABCCCCCC);
        add(1'b0, 64'h10, 3'd3, 64'h0);
        run_seq(0, 1'b0);
        chk("byte_merge_data", 0, r_rdata[1], 64'h11223344AB667788);

        // Zero wait states: back-to-back write/read, then error responses.
        s_n = 0;
        add(1'b1, 64'h20, 3'd3, 64'h000000000000DEAD);
        add(1'b0, 64'h20, 3'd3, 64'h0);
        run_seq(1, 1'b0);
        chk("ws0_write_lows", 1, 64'(r_lows[0]), 64'd0);
        chk("ws0_read_lows", 1, 64'(r_lows[1]), 64'd0);
        chk("ws0_raw_data", 1, r_rdata[1], 64'h000000000000DEAD);

        s_n = 0;
        add(1'b1, 64'h21, 3'd1, 64'hFFFFFFFFFFFFFFFF);
        add(1'b0, 64'h800 * 8, 3'd3, 64'h0);
        add(1'b0, 64'h20, 3'd3, 64'h0);
        run_seq(1, 1'b0);
        chk("misalign_err1", 1, 64'(r_err1[0]), 64'd1);
        chk("misalign_lows", 1, 64'(r_lows[0]), 64'd1);
        chk("misalign_err2", 1, 64'(r_resp[0]), 64'd1);
        chk("range_err1", 1, 64'(r_err1[1]), 64'd1);
        chk("range_lows", 1, 64'(r_lows[1]), 64'd1);
        chk("range_err2", 1, 64'(r_resp[1]), 64'd1);
        chk("err_no_write", 1, r_rdata[2], 64'h000000000000DEAD);

        // Reset aborting a write in WAIT and in DATA.
        s_n = 0;
        add(1'b1, 64'h30, 3'd3, 64'h0123456789ABCDEF);
        run_seq(0, 1'b1);
        reset_during(0, 64'h30, 64'hFFFF0000FFFF0000, 0);
        s_n = 0;
        add(1'b0, 64'h30, 3'd3, 64'h0);
        run_seq(0, 1'b1);
        chk("reset_in_wait_keeps", 0, r_rdata[0], 64'h0123456789ABCDEF);
        reset_during(0, 64'h30, 64'h5555AAAA5555AAAA, 1);
        run_seq(0, 1'b1);
        chk("reset_in_data_keeps", 0, r_rdata[0], 64'h0123456789ABCDEF);

        s_n = 0;
        add(1'b1, 64'h30, 3'd3, 64'h0F1E2D3C4B5A6978);
        run_seq(1, 1'b1);
        reset_during(1, 64'h30, 64'hFFFFFFFF00000000, 0);
        s_n = 0;
        add(1'b0, 64'h30, 3'd3, 64'h0);
        run_seq(1, 1'b1);
        chk("ws0_reset_keeps", 1, r_rdata[0], 64'h0F1E2D3C4B5A6978);

        // Random traffic over a small window plus the top word and out-of-range addresses.
        for (int d = 0; d < 2; d++) begin
            s_n = 0;
            for (int w = 0; w < 16; w++) add(1'b1, 64'(w) << 3, 3'd3, {$urandom, $urandom});
            add(1'b1, 64'd511 << 3, 3'd3, {$urandom, $urandom});
            run_seq(d, 1'b0);
            for (int round = 0; round < 2; round++) begin
                s_n = 0;
                for (int i = 0; i < 120; i++) add_random();
                run_seq(d, round[0]);
            end
        end

        repeat (2) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ahb_mem_slave.md
AHB_MEM_SLAVE -- requirements
Module: ahb_mem_slave

Interface
REQ-001 Parameter DEPTH_WORDS, default 512, SHALL set the number of 64-bit storage words.
REQ-002 Parameter BASE_ADDR, default 64'h0, SHALL set the byte address of word 0.
REQ-003 Parameter WAIT_STATES, default 1, range 0-7, SHALL set the HREADY-low cycles per data phase.
REQ-004 CLK  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 RST_N  input  1  SHALL be the synchronous, active-low reset.
REQ-006 HSEL  input  1  SHALL select this slave.
REQ-007 HTRANS  input  1  SHALL mean active transfer when 1 and idle when 0.
REQ-008 HADDR  input  64  SHALL carry the byte address during the address phase.
REQ-009 HWRITE  input  1  SHALL mean write when 1 and read when 0.
REQ-010 HSIZE  input  3  SHALL encode the size: 0=byte, 1=half, 2=word, 3=dword; 4-7 are illegal.
REQ-011 HWDATA  input  64  SHALL carry write data during the data phase, in little-endian byte lanes.
REQ-012 HRDATA  output  64  SHALL carry read data.
REQ-013 HREADY  output  1  SHALL be 1 when the current data phase completes this cycle.
REQ-014 HRESP  output  1  SHALL be 1 during an error response.

Function
REQ-015 Accept: a transfer SHALL be accepted at a rising edge where HSEL=1, HTRANS=1, HREADY=1 and RST_N=1; at acceptance HADDR, HWRITE and HSIZE SHALL be registered.
REQ-016 While HREADY=0, address-phase inputs SHALL be ignored.
REQ-017 FSM states SHALL be IDLE, WAIT, DATA, ERR1 and ERR2.
REQ-018 On acceptance of a legal transfer, the FSM SHALL go to WAIT if WAIT_STATES>0, otherwise to DATA.
REQ-019 WAIT SHALL drive HREADY=0 for exactly WAIT_STATES cycles, counted by a 3-bit down-counter, and then go to DATA.
REQ-020 DATA SHALL drive HREADY=1 and HRESP=0; next state SHALL be IDLE, or the WAIT/DATA/ERR1 entry for a new transfer accepted at the same edge (back-to-back pipelining).
REQ-021 Latency: for an acceptance at edge T, HREADY SHALL be 1 in cycle T+1+WAIT_STATES.
REQ-022 Legal transfer: (HADDR-BASE_ADDR) < DEPTH_WORDS*8, HSIZE<=3, and HADDR aligned to 2^HSIZE bytes.
REQ-023 Illegal transfer: on acceptance the FSM SHALL go to ERR1, with no wait states.
REQ-024 ERR1 SHALL drive HREADY=0, HRESP=1; ERR2 SHALL drive HREADY=1, HRESP=1; ERR2 SHALL then exit exactly as DATA does.
REQ-025 An erroring write SHALL not modify memory.
REQ-026 Word index SHALL be (HADDR-BASE_ADDR)>>3, and the byte lane SHALL be HADDR[2:0].
REQ-027 Write commit: at the edge ending DATA, bytes HADDR[2:0] .. HADDR[2:0]+2^HSIZE-1 of the word SHALL be loaded from the same lanes of HWDATA; other bytes SHALL be unchanged.
REQ-028 Read: in DATA for a read, HRDATA SHALL be the full 64-bit stored word, combinational from the registered index.
REQ-029 In all other states, and for writes, HRDATA SHALL be 0.
REQ-030 A read whose data phase follows a write's data phase to the same word SHALL return the post-write value (read-after-write visible, no stall).
REQ-031 IDLE SHALL drive HREADY=1 and HRESP=0.

Reset
REQ-032 When RST_N=0 at an edge, the FSM SHALL go to IDLE, the wait counter SHALL be 0, and the registered address and control SHALL be 0.
REQ-033 In the cycle after reset: HREADY=1, HRESP=0, HRDATA=0.
REQ-034 Reset mid-transfer SHALL abort it, and a pending write SHALL not commit.
REQ-035 Memory contents SHALL not be reset.
REQ-036 No transfer SHALL be accepted at an edge where RST_N=0.

Verification
REQ-037 WAIT_STATES=1: write dword 0x1122334455667788 to 0x10, then read 0x10 -> HREADY low 1 cycle per transfer; read HRDATA=0x1122334455667788 with HREADY=1.
REQ-038 Byte write of HWDATA lane 3 = 0xAB to 0x13 over the word above, then read 0x10 -> 0x11223344AB667788.
REQ-039 WAIT_STATES=0: back-to-back write 0x20 = 0xDEAD, then read 0x20 with no idle cycle -> HREADY stays 1; read returns 0x000000000000DEAD.
REQ-040 Half-word write to 0x21 (misaligned), then a read of 0x800*8 beyond DEPTH -> each gives ERR1 (HREADY=0, HRESP=1) then ERR2 (HREADY=1, HRESP=1); word 0x20 unchanged.
REQ-041 RST_N=0 during the WAIT cycle of a write to 0x30 -> next cycle HREADY=1, HRESP=0; a subsequent read of 0x30 returns the prior contents.
